// File: rtl/regfile_pc_stack.sv
// regfile_pc_stack: small general-purpose register file paired with a program
// counter that supports increment, jump, relative branch, and call/return
// through a bounded return-address stack. Reads are combinational with a
// write-through bypass. Register writes and PC operations are independent.
module regfile_pc_stack #(
   parameter int DATA_W      = 8,
   parameter int NUM_REGS    = 4,
   parameter int PC_W        = 8,
   parameter int STACK_DEPTH = 4,
   parameter int ZERO_REG    = 0,
   parameter int RESET_PC    = 0,
   localparam int AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              write_enable,
   input  logic [AW-1:0]     write_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic [AW-1:0]     read_addr1,
   input  logic [AW-1:0]     read_addr2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   input  logic [2:0]        pc_op,
   input  logic [PC_W-1:0]   pc_target,
   output logic [PC_W-1:0]   pc_out,
   output logic              stack_full,
   output logic              stack_empty,
   output logic              stack_err
);

   // The stack pointer counts occupied entries, so it needs to reach STACK_DEPTH.
   localparam int SP_W = (STACK_DEPTH > 0) ? $clog2(STACK_DEPTH + 1) : 1;

   localparam logic [AW:0]     REG_COUNT = (AW + 1)'(NUM_REGS);
   localparam logic [SP_W-1:0] SP_FULL   = SP_W'(STACK_DEPTH);
   localparam logic [PC_W-1:0] PC_RESET  = PC_W'(RESET_PC);
   localparam logic            ZERO_EN   = (ZERO_REG != 0);

   typedef enum logic [2:0] {
      PC_HOLD   = 3'b000,
      PC_INC    = 3'b001,
      PC_JUMP   = 3'b010,
      PC_BRANCH = 3'b011,
      PC_CALL   = 3'b100,
      PC_RET    = 3'b101
   } pc_op_e;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [PC_W-1:0]   stack_mem [STACK_DEPTH];

   logic              write_ok;
   logic [PC_W-1:0]   pc;
   logic [PC_W-1:0]   pc_next;
   logic [PC_W-1:0]   pc_inc;
   logic [PC_W-1:0]   stack_top;
   logic [SP_W-1:0]   sp;
   logic [SP_W-1:0]   sp_next;
   logic              push;
   logic              err_set;
   logic              err_q;

   // A write only lands when it targets a real register that is not the hardwired zero.
   always_comb begin
      write_ok = write_enable
                 && ({1'b0, write_addr} < REG_COUNT)
                 && !(ZERO_EN && (write_addr == '0));
   end

   // Read port 1: out-of-range and hardwired-zero addresses return 0, otherwise bypass a same-cycle write.
   always_comb begin
      read_data1 = '0;
      if (({1'b0, read_addr1} < REG_COUNT) && !(ZERO_EN && (read_addr1 == '0))) begin
         if (write_ok && (write_addr == read_addr1)) begin
            read_data1 = write_data;
         end else begin
            read_data1 = regs[read_addr1];
         end
      end
   end

   // Read port 2: identical behaviour to port 1.
   always_comb begin
      read_data2 = '0;
      if (({1'b0, read_addr2} < REG_COUNT) && !(ZERO_EN && (read_addr2 == '0))) begin
         if (write_ok && (write_addr == read_addr2)) begin
            read_data2 = write_data;
         end else begin
            read_data2 = regs[read_addr2];
         end
      end
   end

   // Register storage: cleared by reset, updated by qualified writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (write_ok) begin
         regs[write_addr] <= write_data;
      end
   end

   assign pc_out      = pc;
   assign stack_full  = (sp == SP_FULL);
   assign stack_empty = (sp == '0);
   assign stack_err   = err_q;

   // Return address and top-of-stack view; the top is only consumed when the stack is non-empty.
   always_comb begin
      pc_inc    = pc + PC_W'(1);
      stack_top = stack_mem[sp - SP_W'(1)];
   end

   // Next PC and stack pointer; illegal call/return leave everything alone and flag an error.
   always_comb begin
      pc_next = pc;
      sp_next = sp;
      push    = 1'b0;
      err_set = 1'b0;
      case (pc_op)
         PC_HOLD: begin
         end
         PC_INC: begin
            pc_next = pc_inc;
         end
         PC_JUMP: begin
            pc_next = pc_target;
         end
         PC_BRANCH: begin
            pc_next = pc + pc_target;
         end
         PC_CALL: begin
            if (stack_full) begin
               err_set = 1'b1;
            end else begin
               push    = 1'b1;
               pc_next = pc_target;
               sp_next = sp + SP_W'(1);
            end
         end
         PC_RET: begin
            if (stack_empty) begin
               err_set = 1'b1;
            end else begin
               pc_next = stack_top;
               sp_next = sp - SP_W'(1);
            end
         end
         default: begin
         end
      endcase
   end

   // Stack storage needs no reset: entries above the pointer are never read.
   always_ff @(posedge clk) begin
      if (push) begin
         stack_mem[sp] <= pc_inc;
      end
   end

   // PC, stack pointer and sticky error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc    <= PC_RESET;
         sp    <= '0;
         err_q <= 1'b0;
      end else begin
         pc    <= pc_next;
         sp    <= sp_next;
         err_q <= err_q | err_set;
      end
   end

endmodule

// File: tb/tb_regfile_pc_stack.sv
// tb_regfile_pc_stack: directed checks of the register file (bypass, zero
// register, out-of-range addresses) and the PC / return-stack behaviour.
// dut_a uses ZERO_REG=1 and a non-zero reset PC; dut_b uses ZERO_REG=0 so
// that R0 behaves as an ordinary register.
module tb_regfile_pc_stack;

   localparam logic [2:0] OP_HOLD   = 3'b000;
   localparam logic [2:0] OP_INC    = 3'b001;
   localparam logic [2:0] OP_JUMP   = 3'b010;
   localparam logic [2:0] OP_BRANCH = 3'b011;
   localparam logic [2:0] OP_CALL   = 3'b100;
   localparam logic [2:0] OP_RET    = 3'b101;

   logic       clk;
   logic       reset;
   logic       write_enable;
   logic [2:0] write_addr;
   logic [7:0] write_data;
   logic [2:0] read_addr1;
   logic [2:0] read_addr2;
   logic [2:0] pc_op;
   logic [7:0] pc_target;

   logic [7:0] read_data1, read_data2, pc_out;
   logic       stack_full, stack_empty, stack_err;

   logic [7:0] b_read_data1, b_read_data2, b_pc_out;
   logic       b_stack_full, b_stack_empty, b_stack_err;

   int n_compared   = 0;
   int n_mismatched = 0;

   regfile_pc_stack #(
      .DATA_W(8), .NUM_REGS(5), .PC_W(8), .STACK_DEPTH(4), .ZERO_REG(1), .RESET_PC(8)
   ) dut_a (
      .clk(clk), .reset(reset),
      .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
      .read_addr1(read_addr1), .read_addr2(read_addr2),
      .read_data1(read_data1), .read_data2(read_data2),
      .pc_op(pc_op), .pc_target(pc_target), .pc_out(pc_out),
      .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
   );

   regfile_pc_stack #(
      .DATA_W(8), .NUM_REGS(5), .PC_W(8), .STACK_DEPTH(4), .ZERO_REG(0), .RESET_PC(0)
   ) dut_b (
      .clk(clk), .reset(reset),
      .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
      .read_addr1(read_addr1), .read_addr2(read_addr2),
      .read_data1(b_read_data1), .read_data2(b_read_data2),
      .pc_op(pc_op), .pc_target(pc_target), .pc_out(b_pc_out),
      .stack_full(b_stack_full), .stack_empty(b_stack_empty), .stack_err(b_stack_err)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      n_compared++;
      assert (observed === expected) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance past one rising edge, landing 1 unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Directed sequence.
   initial begin
      reset        = 1'b1;
      write_enable = 1'b0;
      write_addr   = 3'd0;
      write_data   = 8'h00;
      read_addr1   = 3'd1;
      read_addr2   = 3'd2;
      pc_op        = OP_HOLD;
      pc_target    = 8'h00;
      #2;
      check_output("reset_pc",    pc_out, 8'h08);
      check_output("reset_empty", 8'(stack_empty), 8'h01);
      check_output("reset_full",  8'(stack_full), 8'h00);
      check_output("reset_err",   8'(stack_err), 8'h00);
      check_output("reset_rd1",   read_data1, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      step();

      // Write-through bypass on R2, then the stored value.
      write_enable = 1'b1; write_addr = 3'd2; write_data = 8'h5A;
      read_addr1 = 3'd2; read_addr2 = 3'd3;
      #1;
      check_output("bypass_r2_rd1",   read_data1, 8'h5A);
      check_output("bypass_r2_rd2",   read_data2, 8'h00);
      check_output("bypass_r2_b_rd1", b_read_data1, 8'h5A);
      step();
      write_enable = 1'b0;
      #1;
      check_output("stored_r2_rd1", read_data1, 8'h5A);

      // R0 is hardwired zero on dut_a even under a bypass; writable on dut_b.
      write_enable = 1'b1; write_addr = 3'd0; write_data = 8'hFF;
      read_addr1 = 3'd0; read_addr2 = 3'd0;
      #1;
      check_output("zero_r0_bypass_rd1", read_data1, 8'h00);
      check_output("zero_r0_bypass_rd2", read_data2, 8'h00);
      check_output("b_r0_bypass_rd1",    b_read_data1, 8'hFF);
      step();
      write_enable = 1'b0;
      #1;
      check_output("zero_r0_later_rd1", read_data1, 8'h00);
      check_output("b_r0_stored_rd2",   b_read_data2, 8'hFF);

      // Out-of-range write is dropped and never bypassed; R4 is the last valid register.
      write_enable = 1'b1; write_addr = 3'd5; write_data = 8'h77;
      read_addr1 = 3'd5; read_addr2 = 3'd7;
      #1;
      check_output("oor_bypass_rd1", read_data1, 8'h00);
      check_output("oor_rd2",        read_data2, 8'h00);
      step();
      write_addr = 3'd4; write_data = 8'h33;
      read_addr1 = 3'd5; read_addr2 = 3'd4;
      #1;
      check_output("oor_stored_rd1", read_data1, 8'h00);
      check_output("r4_bypass_rd2",  read_data2, 8'h33);
      step();
      write_enable = 1'b0;
      read_addr1 = 3'd2; read_addr2 = 3'd4;
      #1;
      check_output("dual_read_r2", read_data1, 8'h5A);
      check_output("dual_read_r4", read_data2, 8'h33);

      // Increment wrap and negative branch wrap.
      pc_op = OP_JUMP; pc_target = 8'hFE;
      step();
      check_output("jump_fe", pc_out, 8'hFE);
      pc_op = OP_INC;
      step();
      check_output("inc_ff", pc_out, 8'hFF);
      step();
      check_output("inc_wrap_00", pc_out, 8'h00);
      pc_op = OP_JUMP; pc_target = 8'h10;
      step();
      check_output("jump_10", pc_out, 8'h10);
      pc_op = OP_BRANCH; pc_target = 8'hF0;
      step();
      check_output("branch_neg_wrap", pc_out, 8'h00);
      pc_target = 8'h05;
      step();
      check_output("branch_pos", pc_out, 8'h05);
      pc_op = 3'b110;
      step();
      check_output("reserved_110_hold", pc_out, 8'h05);
      pc_op = 3'b111;
      step();
      check_output("reserved_111_hold", pc_out, 8'h05);

      // A register write and a PC increment in the same cycle both take effect.
      pc_op = OP_INC;
      write_enable = 1'b1; write_addr = 3'd1; write_data = 8'h11;
      step();
      write_enable = 1'b0; pc_op = OP_HOLD; read_addr1 = 3'd1;
      #1;
      check_output("concurrent_pc", pc_out, 8'h06);
      check_output("concurrent_r1", read_data1, 8'h11);

      // Nested call / return.
      pc_op = OP_JUMP; pc_target = 8'h20;
      step();
      check_output("jump_20", pc_out, 8'h20);
      pc_op = OP_CALL; pc_target = 8'h40;
      step();
      check_output("call_40", pc_out, 8'h40);
      check_output("call_40_empty", 8'(stack_empty), 8'h00);
      pc_target = 8'h60;
      step();
      check_output("call_60", pc_out, 8'h60);
      pc_op = OP_RET;
      step();
      check_output("ret_41", pc_out, 8'h41);
      step();
      check_output("ret_21", pc_out, 8'h21);
      check_output("ret_empty", 8'(stack_empty), 8'h01);
      check_output("ret_err", 8'(stack_err), 8'h00);

      // Reset between edges after two calls.
      pc_op = OP_CALL; pc_target = 8'h40;
      step();
      pc_target = 8'h50;
      step();
      check_output("pre_reset_pc", pc_out, 8'h50);
      pc_op = OP_HOLD;
      read_addr1 = 3'd2; read_addr2 = 3'd4;
      reset = 1'b1;
      #1;
      check_output("async_reset_pc",    pc_out, 8'h08);
      check_output("async_reset_empty", 8'(stack_empty), 8'h01);
      check_output("async_reset_err",   8'(stack_err), 8'h00);
      check_output("async_reset_r2",    read_data1, 8'h00);
      check_output("async_reset_r4",    read_data2, 8'h00);
      read_addr1 = 3'd0;
      #1;
      check_output("async_reset_b_r0",  b_read_data1, 8'h00);
      reset = 1'b0;
      pc_op = OP_INC;
      step();
      check_output("first_edge_inc", pc_out, 8'h09);

      // Fill the stack, overflow, then unwind in LIFO order.
      pc_op = OP_CALL; pc_target = 8'h30;
      step();
      pc_target = 8'h31;
      step();
      pc_target = 8'h32;
      step();
      check_output("three_calls_full", 8'(stack_full), 8'h00);
      pc_target = 8'h33;
      step();
      check_output("four_calls_pc",   pc_out, 8'h33);
      check_output("four_calls_full", 8'(stack_full), 8'h01);
      check_output("four_calls_err",  8'(stack_err), 8'h00);
      pc_target = 8'h70;
      step();
      check_output("overflow_pc",   pc_out, 8'h33);
      check_output("overflow_err",  8'(stack_err), 8'h01);
      check_output("overflow_full", 8'(stack_full), 8'h01);
      pc_op = OP_RET;
      step();
      check_output("unwind_1", pc_out, 8'h33);
      check_output("unwind_1_full", 8'(stack_full), 8'h00);
      step();
      check_output("unwind_2", pc_out, 8'h32);
      step();
      check_output("unwind_3", pc_out, 8'h31);
      step();
      check_output("unwind_4", pc_out, 8'h0A);
      check_output("unwind_empty", 8'(stack_empty), 8'h01);
      check_output("err_sticky", 8'(stack_err), 8'h01);

      // Underflow straight after reset.
      pc_op = OP_HOLD;
      reset = 1'b1;
      #2;
      check_output("reset_clears_err", 8'(stack_err), 8'h00);
      reset = 1'b0;
      pc_op = OP_RET;
      step();
      check_output("underflow_pc",  pc_out, 8'h08);
      check_output("underflow_err", 8'(stack_err), 8'h01);
      check_output("underflow_empty", 8'(stack_empty), 8'h01);
      pc_op = OP_HOLD;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
